// File: rtl/regfile_writeback_port_pkg.sv
// Shared types for the register-file writeback front end.
package regfile_writeback_port_pkg;

   localparam int REG_W     = 5;
   localparam int WB_DATA_W = 32;

   typedef logic [REG_W-1:0] regAddr_t;

   localparam regAddr_t REG_ZERO = 5'd0;

   typedef struct packed {
      regAddr_t               register;
      logic [WB_DATA_W-1:0]   data;
   } wbEntry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// DEPTH-entry synchronous FIFO buffering long-latency writebacks.
// full/empty/count are registered so downstream handshakes see no input path.
module regfile_writeback_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         pushData,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   countNext;
   logic             doPush;
   logic             doPop;

   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      countNext = count;
      if (doPush && !doPop)
         countNext = count + CNT_ONE;
      else if (doPop && !doPush)
         countNext = count - CNT_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + PTR_ONE;
         if (doPop)
            rdPtr <= rdPtr + PTR_ONE;
         count <= countNext;
         full  <= (countNext == FULL_COUNT);
         empty <= (countNext == '0);
      end
   end

   // NOTE: storage is not reset; occupancy is tracked by the pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (doPush)
         mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/regfile_writeback_port.sv
// Merges the ALU and long-op writeback sources onto the single register-file
// write port and tracks destinations of in-flight long ops for decode stalls.
module regfile_writeback_port
   import regfile_writeback_port_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Src0Valid,
   input  logic [4:0]               Src0Register,
   input  logic [N-1:0]             Src0Data,
   input  logic                     Src1Valid,
   output logic                     Src1Ready,
   input  logic [4:0]               Src1Register,
   input  logic [N-1:0]             Src1Data,
   input  logic                     IssueValid,
   input  logic [4:0]               IssueRegister,
   input  logic [4:0]               ReadRegister1,
   input  logic [4:0]               ReadRegister2,
   output logic                     Stall1,
   output logic                     Stall2,
   output logic                     RegWrite,
   output logic [4:0]               WriteRegister,
   output logic [N-1:0]             WriteData,
   output logic [$clog2(DEPTH):0]   FifoCount
);

   logic               fifoFull;
   logic               fifoEmpty;
   logic               fifoPush;
   logic               fifoPop;
   logic               outOfReset;
   logic [REG_W+N-1:0] headEntry;
   regAddr_t           headRegister;
   logic [N-1:0]       headData;

   logic               commitValid;
   regAddr_t           commitRegister;
   logic [N-1:0]       commitData;
   logic [31:0]        pending;
   logic [31:0]        pendingNext;

   // Ready is held low during reset and otherwise mirrors the registered full flag.
   assign Src1Ready = outOfReset && !fifoFull;
   assign fifoPush  = Src1Valid && Src1Ready;
   assign fifoPop   = !Src0Valid && !fifoEmpty;

   assign {headRegister, headData} = headEntry;

   regfile_writeback_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REG_W + N)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifoPush),
      .pop      (fifoPop),
      .pushData ({Src1Register, Src1Data}),
      .popData  (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (FifoCount)
   );

   always_comb begin
      commitValid    = 1'b0;
      commitRegister = REG_ZERO;
      commitData     = '0;
      if (Src0Valid) begin
         commitValid    = 1'b1;
         commitRegister = Src0Register;
         commitData     = Src0Data;
      end else if (!fifoEmpty) begin
         commitValid    = 1'b1;
         commitRegister = headRegister;
         commitData     = headData;
      end
   end

   // Clear before set so an issue landing on the same edge as its retirement keeps the bit.
   always_comb begin
      pendingNext = pending;
      if (fifoPop && headRegister != REG_ZERO)
         pendingNext[headRegister] = 1'b0;
      if (IssueValid && IssueRegister != REG_ZERO)
         pendingNext[IssueRegister] = 1'b1;
   end

   assign Stall1 = pending[ReadRegister1];
   assign Stall2 = pending[ReadRegister2];

   always_ff @(posedge clk) begin
      if (reset) begin
         RegWrite      <= 1'b0;
         WriteRegister <= REG_ZERO;
         WriteData     <= '0;
         pending       <= '0;
         outOfReset    <= 1'b0;
      end else begin
         RegWrite <= commitValid && (commitRegister != REG_ZERO);
         if (commitValid && commitRegister != REG_ZERO) begin
            WriteRegister <= commitRegister;
            WriteData     <= commitData;
         end
         pending    <= pendingNext;
         outOfReset <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_writeback_port.sv
// Self-checking bench: directed scenarios then random traffic, compared every
// cycle against a queue-based reference model of the writeback port.
module tb_regfile_writeback_port;
   import regfile_writeback_port_pkg::*;

   localparam int N     = 32;
   localparam int DEPTH = 2;

   logic          clk;
   logic          reset;
   logic          Src0Valid;
   logic [4:0]    Src0Register;
   logic [N-1:0]  Src0Data;
   logic          Src1Valid;
   logic          Src1Ready;
   logic [4:0]    Src1Register;
   logic [N-1:0]  Src1Data;
   logic          IssueValid;
   logic [4:0]    IssueRegister;
   logic [4:0]    ReadRegister1;
   logic [4:0]    ReadRegister2;
   logic          Stall1;
   logic          Stall2;
   logic          RegWrite;
   logic [4:0]    WriteRegister;
   logic [N-1:0]  WriteData;
   logic [1:0]    FifoCount;

   regfile_writeback_port #(.N(N), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .Src0Valid     (Src0Valid),
      .Src0Register  (Src0Register),
      .Src0Data      (Src0Data),
      .Src1Valid     (Src1Valid),
      .Src1Ready     (Src1Ready),
      .Src1Register  (Src1Register),
      .Src1Data      (Src1Data),
      .IssueValid    (IssueValid),
      .IssueRegister (IssueRegister),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .Stall1        (Stall1),
      .Stall2        (Stall2),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .FifoCount     (FifoCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;

   // Inputs for the next cycle; applied at the falling edge by step().
   logic          nReset, nS0v, nS1v, nIv;
   logic [4:0]    nS0r, nS1r, nIr, nR1, nR2;
   logic [N-1:0]  nS0d, nS1d;

   // Reference model state.
   wbEntry_t      mQ[$];
   bit [31:0]     mPending;
   bit            mOutOfReset;
   bit            mRegWrite;
   bit [4:0]      mWReg;
   bit [N-1:0]    mWData;
   bit            modelValid = 1'b0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic idleInputs();
      nReset = 1'b0; nS0v = 1'b0; nS1v = 1'b0; nIv = 1'b0;
      nS0r = '0; nS1r = '0; nIr = '0; nR1 = '0; nR2 = '0;
      nS0d = '0; nS1d = '0;
   endtask

   task automatic modelUpdate();
      wbEntry_t e;
      bit       commit;
      bit       pushOk;
      if (nReset) begin
         mQ.delete();
         mPending    = '0;
         mRegWrite   = 1'b0;
         mWReg       = '0;
         mWData      = '0;
         mOutOfReset = 1'b0;
         modelValid  = 1'b1;
         return;
      end
      pushOk = nS1v && mOutOfReset && (mQ.size() < DEPTH);
      commit = 1'b0;
      e      = '0;
      if (nS0v) begin
         e.register = nS0r;
         e.data     = nS0d;
         commit     = 1'b1;
      end else if (mQ.size() > 0) begin
         e      = mQ.pop_front();
         commit = 1'b1;
         mPending[e.register] = 1'b0;
      end
      mRegWrite = commit && (e.register != 5'd0);
      if (mRegWrite) begin
         mWReg  = e.register;
         mWData = e.data;
      end
      if (nIv && nIr != 5'd0)
         mPending[nIr] = 1'b1;
      if (pushOk)
         mQ.push_back('{register: nS1r, data: nS1d});
      mOutOfReset = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      reset         = nReset;
      Src0Valid     = nS0v;
      Src0Register  = nS0r;
      Src0Data      = nS0d;
      Src1Valid     = nS1v;
      Src1Register  = nS1r;
      Src1Data      = nS1d;
      IssueValid    = nIv;
      IssueRegister = nIr;
      ReadRegister1 = nR1;
      ReadRegister2 = nR2;
      #1;
      if (modelValid) begin
         check("Src1Ready",     Src1Ready,     mOutOfReset && (mQ.size() < DEPTH));
         check("FifoCount",     FifoCount,     mQ.size());
         check("Stall1",        Stall1,        mPending[nR1]);
         check("Stall2",        Stall2,        mPending[nR2]);
         check("RegWrite",      RegWrite,      mRegWrite);
         check("WriteRegister", WriteRegister, mWReg);
         check("WriteData",     WriteData,     mWData);
      end
      modelUpdate();
   endtask

   initial begin
      idleInputs();
      step();

      // Reset with a src0 request present: no write, ready low.
      nReset = 1'b1; nS0v = 1'b1; nS0r = 5'd5; nS0d = 32'hDEAD_BEEF;
      step(); step();
      check("reset_ready_low", Src1Ready, 1'b0);
      idleInputs();
      step(); step();
      check("ready_after_reset", Src1Ready, 1'b1);

      // Single src0 write, then hold.
      nS0v = 1'b1; nS0r = 5'd8; nS0d = 32'h0000_1234;
      step();
      idleInputs();
      step();
      check("src0_write_reg", WriteRegister, 5'd8);
      step();
      check("src0_hold_data", WriteData, 32'h0000_1234);

      // src0 busy while src1 fills the FIFO.
      for (int i = 0; i < 4; i++) begin
         nS0v = 1'b1; nS0r = 5'(20 + i); nS0d = 32'(100 + i);
         nS1v = 1'b1;
         nS1r = (i == 0) ? 5'd16 : (i == 1) ? 5'd17 : 5'd18;
         nS1d = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
         step();
         if (i == 2) begin
            check("fill_count", FifoCount, 2'd2);
            check("fill_ready", Src1Ready, 1'b0);
         end
      end
      idleInputs();
      repeat (4) step();
      check("drain_count", FifoCount, 2'd0);

      // Scoreboard set, clear on src1 commit, and same-cycle set/clear.
      nIv = 1'b1; nIr = 5'd9;
      step();
      idleInputs(); nR1 = 5'd9;
      step();
      check("stall_set", Stall1, 1'b1);
      nR1 = 5'd9; nS1v = 1'b1; nS1r = 5'd9; nS1d = 32'h77;
      step();
      idleInputs(); nR1 = 5'd9;
      step(); step();
      check("stall_clear", Stall1, 1'b0);
      nIv = 1'b1; nIr = 5'd9; nR1 = 5'd9;
      step();
      idleInputs(); nR1 = 5'd9; nS1v = 1'b1; nS1r = 5'd9; nS1d = 32'h88;
      step();
      idleInputs(); nR1 = 5'd9; nIv = 1'b1; nIr = 5'd9;
      step();
      idleInputs(); nR1 = 5'd9;
      step();
      check("stall_set_wins", Stall1, 1'b1);

      // Register 0: consumed without a write, never pending.
      idleInputs(); nS1v = 1'b1; nS1r = 5'd0; nS1d = 32'hFFFF_FFFF;
      step();
      idleInputs(); nIv = 1'b1; nIr = 5'd0;
      step(); step();
      check("reg0_no_write", RegWrite, 1'b0);
      check("reg0_no_stall", Stall2, 1'b0);

      // Full FIFO with src0 idle: pop does not enable a same-cycle push.
      for (int i = 0; i < 2; i++) begin
         idleInputs(); nS0v = 1'b1; nS0r = 5'd1; nS0d = 32'(i);
         nS1v = 1'b1; nS1r = 5'(2 + i); nS1d = 32'(50 + i);
         step();
      end
      idleInputs(); nS1v = 1'b1; nS1r = 5'd4; nS1d = 32'h44;
      step(); step(); step();
      idleInputs();
      repeat (4) step();

      // Reset with two entries buffered.
      for (int i = 0; i < 2; i++) begin
         idleInputs(); nS0v = 1'b1; nS0r = 5'd3; nS0d = 32'(i);
         nS1v = 1'b1; nS1r = 5'(10 + i); nS1d = 32'(60 + i);
         nIv = 1'b1; nIr = 5'(10 + i); nR1 = 5'd10; nR2 = 5'd11;
         step();
      end
      idleInputs(); nReset = 1'b1;
      step();
      idleInputs(); nR1 = 5'd10; nR2 = 5'd11;
      step(); step();
      check("reset_flush_count", FifoCount, 2'd0);
      check("reset_flush_stall", Stall1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         nReset = ($urandom_range(0, 199) == 0);
         nS0v   = ($urandom_range(0, 2) == 0);
         nS0r   = 5'($urandom_range(0, 31));
         nS0d   = $urandom;
         nS1v   = ($urandom_range(0, 1) == 0);
         nS1r   = 5'($urandom_range(0, 15));
         nS1d   = $urandom;
         nIv    = ($urandom_range(0, 3) == 0);
         nIr    = 5'($urandom_range(0, 15));
         nR1    = 5'($urandom_range(0, 15));
         nR2    = 5'($urandom_range(0, 15));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
